fir_multich_fetch_stage: RTL and testbench

FIR_MULTICH_FETCH_STAGE -- requirements
Module: fir_multich_fetch_stage

---
 rtl/fir_pkg.sv | 10 +
 rtl/fir_multich_fetch_stage_if.sv | 31 +++
 rtl/fir_coeff_bank.sv | 48 ++++
 rtl/fir_multich_fetch_stage.sv | 179 +++++++++++++++++
 tb/tb_fir_multich_fetch_stage.sv | 310 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fir_pkg.sv
// Shared types for the multichannel FIR fetch stage.
package fir_pkg;

    // RUN pairs incoming samples with coefficients; INIT loads one channel's coefficients.
    typedef enum logic {
        RUN  = 1'b0,
        INIT = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/fir_multich_fetch_stage_if.sv
// Sample-in / pair-out stream bundle of the fetch stage.
interface fir_multich_fetch_stage_if #(
    parameter int unsigned INPUT_WIDTH = 32,
    parameter int unsigned CH_WIDTH    = 2
) ();

    logic                   in_valid;
    logic                   in_ready;
    logic [INPUT_WIDTH-1:0] in_data;
    logic [CH_WIDTH-1:0]    in_ch;

    logic                   out_valid;
    logic                   out_ready;
    logic [INPUT_WIDTH-1:0] out_data;
    logic [INPUT_WIDTH-1:0] out_coeff;
    logic [CH_WIDTH-1:0]    out_ch;
    logic                   out_last;

    // Producer of samples and consumer of pairs.
    modport master (
        output in_valid, in_data, in_ch, out_ready,
        input  in_ready, out_valid, out_data, out_coeff, out_ch, out_last
    );

    // The fetch stage itself.
    modport slave (
        input  in_valid, in_data, in_ch, out_ready,
        output in_ready, out_valid, out_data, out_coeff, out_ch, out_last
    );

endinterface

// File: rtl/fir_coeff_bank.sv
// Coefficient storage: one write port, one registered read port, addressed {channel, tap}.
module fir_coeff_bank #(
    parameter int unsigned FS_WIDTH    = 6,
    parameter int unsigned INPUT_WIDTH = 32,
    parameter int unsigned CH_WIDTH    = 2
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         we_i,
    input  logic [CH_WIDTH+FS_WIDTH-1:0] waddr_i,
    input  logic [INPUT_WIDTH-1:0]       wdata_i,
    input  logic                         re_i,
    input  logic [CH_WIDTH+FS_WIDTH-1:0] raddr_i,
    output logic [INPUT_WIDTH-1:0]       rdata_o
);

    localparam int unsigned DEPTH = 1 << (CH_WIDTH + FS_WIDTH);

    logic [INPUT_WIDTH-1:0] mem [DEPTH];
    logic [INPUT_WIDTH-1:0] rdata_q, rdata_d;

    // Write port; the array itself is intentionally left unreset.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
    end

    // Read register only updates on a read so a stalled pair keeps its coefficient.
    always_comb begin
        rdata_d = rdata_q;
        if (re_i) begin
            rdata_d = mem[raddr_i];
        end
    end

    // Read data register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/fir_multich_fetch_stage.sv
// Multichannel FIR fetch stage: pairs each sample with its channel's next coefficient and
// loads coefficient sets one channel at a time.
module fir_multich_fetch_stage
    import fir_pkg::*;
#(
    parameter int unsigned FS_WIDTH    = 6,
    parameter int unsigned INPUT_WIDTH = 32,
    parameter int unsigned CH_WIDTH    = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    fir_multich_fetch_stage_if.slave   bus,
    input  logic                       init_start,
    input  logic [CH_WIDTH-1:0]        init_ch,
    input  logic                       flush,
    input  logic [FS_WIDTH-1:0]        filter_size,
    input  logic                       overflow_in,
    output logic                       init_busy,
    output logic                       init_done,
    output logic                       error_flag,
    output logic [CH_WIDTH-1:0]        error_ch
);

    localparam int unsigned NUM_CH = 1 << CH_WIDTH;

    typedef logic [FS_WIDTH-1:0] tap_t;

    fetch_state_t           state_q, state_d;
    tap_t                   tap_q [NUM_CH];
    tap_t                   tap_d [NUM_CH];
    tap_t                   wcnt_q, wcnt_d;
    logic [CH_WIDTH-1:0]    init_ch_q, init_ch_d;
    logic                   out_valid_q, out_valid_d;
    logic [INPUT_WIDTH-1:0] out_data_q, out_data_d;
    logic [CH_WIDTH-1:0]    out_ch_q, out_ch_d;
    logic                   out_last_q, out_last_d;
    logic                   init_done_q, init_done_d;
    logic                   error_flag_q, error_flag_d;
    logic [CH_WIDTH-1:0]    error_ch_q, error_ch_d;

    logic                   in_ready_c;
    logic                   run_accept;
    logic                   init_write;
    tap_t                   cur_tap;
    logic                   cur_last;
    logic [INPUT_WIDTH-1:0] coeff;

    // Input handshake: loads never back-pressure, samples wait for the output slot.
    always_comb begin
        if (state_q == INIT) begin
            in_ready_c = ~flush;
        end else begin
            in_ready_c = (~out_valid_q | bus.out_ready) & ~flush;
        end
    end

    assign run_accept = bus.in_valid & in_ready_c & (state_q == RUN);
    assign init_write = bus.in_valid & in_ready_c & (state_q == INIT);
    assign cur_tap    = tap_q[bus.in_ch];
    assign cur_last   = cur_tap >= filter_size;

    // Next-state logic for the FSM, tap/write counters, output pair and error capture.
    always_comb begin
        state_d      = state_q;
        tap_d        = tap_q;
        wcnt_d       = wcnt_q;
        init_ch_d    = init_ch_q;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_ch_d     = out_ch_q;
        out_last_d   = out_last_q;
        init_done_d  = 1'b0;
        error_flag_d = error_flag_q;
        error_ch_d   = error_ch_q;

        if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end
        if (run_accept) begin
            out_valid_d         = 1'b1;
            out_data_d          = bus.in_data;
            out_ch_d            = bus.in_ch;
            out_last_d          = cur_last;
            tap_d[bus.in_ch]    = cur_last ? '0 : cur_tap + tap_t'(1);
        end

        case (state_q)
            RUN: begin
                if (init_start) begin
                    state_d   = INIT;
                    init_ch_d = init_ch;
                    wcnt_d    = '0;
                end
            end
            INIT: begin
                if (init_write) begin
                    if (wcnt_q == filter_size) begin
                        state_d          = RUN;
                        tap_d[init_ch_q] = '0;
                        init_done_d      = 1'b1;
                    end else begin
                        wcnt_d = wcnt_q + tap_t'(1);
                    end
                end
            end
            default: state_d = RUN;
        endcase

        // Flush wins over everything, including a same-cycle init_start.
        if (flush) begin
            state_d     = RUN;
            tap_d       = '{default: '0};
            wcnt_d      = '0;
            out_valid_d = 1'b0;
            init_done_d = 1'b0;
        end

        if (overflow_in && !error_flag_q) begin
            error_flag_d = 1'b1;
            error_ch_d   = out_ch_q;
        end
    end

    // State registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= RUN;
            tap_q        <= '{default: '0};
            wcnt_q       <= '0;
            init_ch_q    <= '0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_ch_q     <= '0;
            out_last_q   <= 1'b0;
            init_done_q  <= 1'b0;
            error_flag_q <= 1'b0;
            error_ch_q   <= '0;
        end else begin
            state_q      <= state_d;
            tap_q        <= tap_d;
            wcnt_q       <= wcnt_d;
            init_ch_q    <= init_ch_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_ch_q     <= out_ch_d;
            out_last_q   <= out_last_d;
            init_done_q  <= init_done_d;
            error_flag_q <= error_flag_d;
            error_ch_q   <= error_ch_d;
        end
    end

    fir_coeff_bank #(
        .FS_WIDTH    (FS_WIDTH),
        .INPUT_WIDTH (INPUT_WIDTH),
        .CH_WIDTH    (CH_WIDTH)
    ) u_coeff_bank (
        .clk_i   (clk),
        .rst_i   (rst),
        .we_i    (init_write),
        .waddr_i ({init_ch_q, wcnt_q}),
        .wdata_i (bus.in_data),
        .re_i    (run_accept),
        .raddr_i ({bus.in_ch, cur_tap}),
        .rdata_o (coeff)
    );

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_coeff = coeff;
    assign bus.out_ch    = out_ch_q;
    assign bus.out_last  = out_last_q;
    assign init_busy     = (state_q == INIT);
    assign init_done     = init_done_q;
    assign error_flag    = error_flag_q;
    assign error_ch      = error_ch_q;

endmodule

// File: tb/tb_fir_multich_fetch_stage.sv
// Self-checking bench for fir_multich_fetch_stage (FS_WIDTH=3, CH_WIDTH=2).
module tb_fir_multich_fetch_stage;

    localparam int unsigned FS_WIDTH    = 3;
    localparam int unsigned INPUT_WIDTH = 32;
    localparam int unsigned CH_WIDTH    = 2;
    localparam int unsigned NUM_CH      = 4;
    localparam int unsigned NUM_TAPS    = 8;

    typedef struct packed {
        logic [31:0] data;
        logic [31:0] coeff;
        logic [1:0]  ch;
        logic        last;
    } pair_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        init_start, flush, overflow_in;
    logic [1:0]  init_ch;
    logic [2:0]  filter_size;
    logic        init_busy, init_done, error_flag;
    logic [1:0]  error_ch;

    int          tests = 0;
    int          fails = 0;

    // Reference model: coefficient table, per-channel batch position, pending output pairs.
    logic [31:0] model_mem [NUM_CH][NUM_TAPS];
    int unsigned model_tap [NUM_CH];
    pair_t       exp_q [$];
    logic [31:0] req38_coeff [5];
    logic [31:0] w0, w1;

    fir_multich_fetch_stage_if #(.INPUT_WIDTH(INPUT_WIDTH), .CH_WIDTH(CH_WIDTH)) bus ();

    fir_multich_fetch_stage #(
        .FS_WIDTH    (FS_WIDTH),
        .INPUT_WIDTH (INPUT_WIDTH),
        .CH_WIDTH    (CH_WIDTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .init_start  (init_start),
        .init_ch     (init_ch),
        .flush       (flush),
        .filter_size (filter_size),
        .overflow_in (overflow_in),
        .init_busy   (init_busy),
        .init_done   (init_done),
        .error_flag  (error_flag),
        .error_ch    (error_ch)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Taps of a batch run 0..filter_size; a position past filter_size also closes the batch.
    function automatic pair_t model_accept(input logic [1:0] ch, input logic [31:0] d);
        pair_t p;
        p.data  = d;
        p.ch    = ch;
        p.coeff = model_mem[ch][model_tap[ch]];
        p.last  = (model_tap[ch] >= int'(filter_size));
        model_tap[ch] = p.last ? 0 : model_tap[ch] + 1;
        return p;
    endfunction

    function automatic void model_clear();
        for (int c = 0; c < NUM_CH; c++) model_tap[c] = 0;
        exp_q.delete();
    endfunction

    // One RUN-mode clock cycle with scoreboard update and output checks.
    task automatic cycle(input bit v, input logic [1:0] ch, input logic [31:0] d, input bit rdy);
        bit exp_ready;
        bit fire_in;
        bit fire_out;
        bus.in_valid  = v;
        bus.in_ch     = ch;
        bus.in_data   = d;
        bus.out_ready = rdy;
        exp_ready = (exp_q.size() == 0) || rdy;
        fire_out  = (exp_q.size() != 0) && rdy;
        fire_in   = v && exp_ready;
        #1;
        check("in_ready", bus.in_ready, exp_ready);
        step();
        if (fire_out) void'(exp_q.pop_front());
        if (fire_in) exp_q.push_back(model_accept(ch, d));
        check("out_valid", bus.out_valid, exp_q.size() != 0);
        if (exp_q.size() != 0) begin
            check("out_data", bus.out_data, exp_q[0].data);
            check("out_coeff", bus.out_coeff, exp_q[0].coeff);
            check("out_ch", bus.out_ch, exp_q[0].ch);
            check("out_last", bus.out_last, exp_q[0].last);
        end
    endtask

    // Load filter_size+1 words into a channel; init_start/in_ch noise must be ignored.
    task automatic load_ch(input logic [1:0] ch, input bit directed);
        logic [31:0] w;
        if (exp_q.size() != 0) cycle(1'b0, 2'd0, 32'd0, 1'b1);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        init_start    = 1'b1;
        init_ch       = ch;
        step();
        init_start = 1'b0;
        check("init_busy_enter", init_busy, 1'b1);
        for (int i = 0; i <= int'(filter_size); i++) begin
            w = directed ? 32'(10 + i) : $urandom;
            bus.in_valid = 1'b1;
            bus.in_data  = w;
            bus.in_ch    = 2'($urandom_range(3));
            init_start   = 1'($urandom_range(1));
            init_ch      = 2'($urandom_range(3));
            #1;
            check("init_in_ready", bus.in_ready, 1'b1);
            check("init_busy", init_busy, 1'b1);
            check("init_done_early", init_done, 1'b0);
            step();
            model_mem[ch][i] = w;
        end
        bus.in_valid = 1'b0;
        init_start   = 1'b0;
        check("init_done_pulse", init_done, 1'b1);
        check("init_busy_exit", init_busy, 1'b0);
        step();
        check("init_done_clear", init_done, 1'b0);
        model_tap[ch] = 0;
    endtask

    task automatic rand_phase(input int n);
        for (int i = 0; i < n; i++) begin
            cycle($urandom_range(3) != 0, 2'($urandom_range(3)), $urandom,
                  $urandom_range(3) != 0);
        end
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_ch     = '0;
        bus.out_ready = 1'b1;
        init_start    = 1'b0;
        init_ch       = '0;
        flush         = 1'b0;
        overflow_in   = 1'b0;
        filter_size   = 3'd3;
        req38_coeff   = '{32'd10, 32'd11, 32'd12, 32'd13, 32'd10};
        model_clear();

        // Asynchronous reset values, sampled before any clock edge.
        #1 rst = 1'b1;
        #2;
        check("rst_out_valid", bus.out_valid, 1'b0);
        check("rst_out_data", bus.out_data, 32'd0);
        check("rst_out_coeff", bus.out_coeff, 32'd0);
        check("rst_out_last", bus.out_last, 1'b0);
        check("rst_init_busy", init_busy, 1'b0);
        check("rst_init_done", init_done, 1'b0);
        check("rst_error_flag", error_flag, 1'b0);
        check("rst_error_ch", error_ch, 2'd0);
        check("rst_in_ready", bus.in_ready, 1'b1);
        step();
        rst = 1'b0;
        step();

        // Directed load of ch1, then random coefficient sets for the other channels.
        load_ch(2'd1, 1'b1);
        load_ch(2'd0, 1'b0);
        load_ch(2'd2, 1'b0);
        load_ch(2'd3, 1'b0);

        // Five back-to-back ch1 samples walk the taps and wrap.
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, 2'd1, $urandom, 1'b1);
            check("req38_coeff", bus.out_coeff, req38_coeff[i]);
            check("req38_last", bus.out_last, i == 3);
        end

        // Interleaved ch0/ch1 traffic.
        for (int i = 0; i < 16; i++) begin
            cycle(1'b1, 2'($urandom_range(1)), $urandom, 1'b1);
        end

        // Back-pressure: three stalled cycles then release; the waiting sample must appear.
        w0 = $urandom;
        w1 = $urandom;
        cycle(1'b1, 2'd2, w0, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b1, 2'd0, w1, 1'b0);
        cycle(1'b1, 2'd0, w1, 1'b1);
        check("stall_sample_kept", bus.out_data, w1);
        cycle(1'b0, 2'd0, 32'd0, 1'b1);

        rand_phase(300);

        // Load started with an output pending, aborted by flush after two writes.
        cycle(1'b0, 2'd0, 32'd0, 1'b1);
        cycle(1'b1, 2'd1, $urandom, 1'b0);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        init_start    = 1'b1;
        init_ch       = 2'd2;
        step();
        init_start = 1'b0;
        check("init_busy_pend", init_busy, 1'b1);
        check("pend_hold_valid", bus.out_valid, 1'b1);
        check("pend_hold_data", bus.out_data, exp_q[0].data);
        w0 = $urandom;
        bus.in_valid  = 1'b1;
        bus.in_data   = w0;
        bus.out_ready = 1'b1;
        #1;
        check("init_ready_pend", bus.in_ready, 1'b1);
        step();
        exp_q.delete();
        model_mem[2][0] = w0;
        check("pend_drained", bus.out_valid, 1'b0);
        w1 = $urandom;
        bus.in_data = w1;
        step();
        model_mem[2][1] = w1;
        flush      = 1'b1;
        init_start = 1'b1;
        init_ch    = 2'd3;
        #1;
        check("flush_in_ready", bus.in_ready, 1'b0);
        step();
        flush        = 1'b0;
        init_start   = 1'b0;
        bus.in_valid = 1'b0;
        model_clear();
        check("flush_init_busy", init_busy, 1'b0);
        check("flush_no_done", init_done, 1'b0);
        step();
        check("flush_no_done_late", init_done, 1'b0);
        check("flush_stays_run", init_busy, 1'b0);
        cycle(1'b1, 2'd1, $urandom, 1'b1);
        cycle(1'b1, 2'd2, $urandom, 1'b1);
        cycle(1'b1, 2'd2, $urandom, 1'b1);

        // Flush in RUN clears a pending pair and beats a same-cycle init_start.
        cycle(1'b1, 2'd0, $urandom, 1'b0);
        bus.in_valid = 1'b0;
        flush        = 1'b1;
        init_start   = 1'b1;
        init_ch      = 2'd1;
        step();
        flush      = 1'b0;
        init_start = 1'b0;
        model_clear();
        check("flush_out_valid", bus.out_valid, 1'b0);
        check("flush_beats_init", init_busy, 1'b0);
        cycle(1'b1, 2'd0, $urandom, 1'b1);

        // Sticky overflow capture.
        cycle(1'b0, 2'd0, 32'd0, 1'b1);
        cycle(1'b1, 2'd2, $urandom, 1'b0);
        check("ovf_none_yet", error_flag, 1'b0);
        bus.in_valid = 1'b0;
        overflow_in  = 1'b1;
        step();
        overflow_in = 1'b0;
        check("ovf_flag", error_flag, 1'b1);
        check("ovf_ch", error_ch, 2'd2);
        cycle(1'b0, 2'd0, 32'd0, 1'b1);
        cycle(1'b1, 2'd0, $urandom, 1'b0);
        bus.in_valid = 1'b0;
        overflow_in  = 1'b1;
        step();
        overflow_in = 1'b0;
        check("ovf_flag_kept", error_flag, 1'b1);
        check("ovf_ch_kept", error_ch, 2'd2);
        rst = 1'b1;
        #2;
        check("rst2_error_flag", error_flag, 1'b0);
        check("rst2_error_ch", error_ch, 2'd0);
        check("rst2_out_valid", bus.out_valid, 1'b0);
        check("rst2_out_data", bus.out_data, 32'd0);
        step();
        rst = 1'b0;
        model_clear();
        // Coefficients survive reset.
        cycle(1'b1, 2'd1, $urandom, 1'b1);

        // Full-depth filter.
        filter_size = 3'd7;
        for (int c = 0; c < NUM_CH; c++) load_ch(2'(c), 1'b0);
        rand_phase(300);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
